ksz8851_bus_cycle: RTL and testbench

- Host-bus cycle engine for the KSZ8851 16-bit parallel interface; sits directly downstream of the transmit/receive sequencers.
- Takes one register-access request (offset, length, WR, writeData) per command and generates CSn/RDn/WRn/CMD strobes and the data bus.
- Publishes its current bus state and the last read word so the sequencer can step on state boundaries.
- Supports back-to-back commands and a dummy-address burst mode (no command phase) for QMU DMA frame writes.

---
 rtl/ksz8851_bus_cycle_if.sv | 33 +++
 rtl/ksz8851_bus_cycle.sv | 147 ++++++++++++++
 tb/tb_ksz8851_bus_cycle.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksz8851_bus_cycle_if.sv
// Host-side bundle for the KSZ8851 bus cycle engine: the register-access
// request from the sequencer, the published status, and the chip-facing pins.
interface ksz8851_bus_cycle_if;
    logic [7:0]  offset;
    logic        length;
    logic        WR;
    logic [15:0] writeData;
    logic        NewCommand;
    logic        Dummy_Write;
    logic [3:0]  state;
    logic [15:0] readData;
    logic        eth_csn;
    logic        eth_rdn;
    logic        eth_wrn;
    logic        eth_cmd;
    logic [15:0] eth_data_out;
    logic        eth_data_oe;
    logic [15:0] eth_data_in;

    // Engine side: takes requests and the bus input, drives strobes and status.
    modport slave (
        input  offset, length, WR, writeData, NewCommand, Dummy_Write, eth_data_in,
        output state, readData, eth_csn, eth_rdn, eth_wrn, eth_cmd,
               eth_data_out, eth_data_oe
    );

    // Sequencer / chip side: issues requests and supplies the bus input.
    modport master (
        output offset, length, WR, writeData, NewCommand, Dummy_Write, eth_data_in,
        input  state, readData, eth_csn, eth_rdn, eth_wrn, eth_cmd,
               eth_data_out, eth_data_oe
    );
endinterface

// File: rtl/ksz8851_bus_cycle.sv
// KSZ8851 16-bit parallel host-bus cycle engine. Each request becomes a
// command (address) phase followed by a read or write data phase; a
// Dummy_Write burst repeats write data phases with no command phase.
// Strobes are decoded straight from the state so a reset releases them
// at the same edge that forces the engine back to Wait.
module ksz8851_bus_cycle #(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic             clk40m,
    input  logic             reset,
    ksz8851_bus_cycle_if.slave bus
);

    typedef enum logic [3:0] {
        ST_ADDR0  = 4'd0,
        ST_ADDR1  = 4'd1,
        ST_ADDR2  = 4'd2,
        ST_READ0  = 4'd3,
        ST_READ1  = 4'd4,
        ST_READ2  = 4'd5,
        ST_WRITE0 = 4'd6,
        ST_WRITE1 = 4'd7,
        ST_WRITE2 = 4'd8,
        ST_WAIT   = 4'd9
    } cycle_state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    cycle_state_t cur_state;
    cycle_state_t next_state;
    logic [3:0]   strobe_cnt;
    logic         strobe_done;
    logic         wr_q;
    logic [15:0]  data_reg;
    logic [15:0]  read_reg;
    logic [3:0]   byte_en;
    logic         csn;
    logic         rdn;
    logic         wrn;
    logic         cmd_phase;
    logic         drive_en;

    assign strobe_done = (strobe_cnt == STROBE_LAST);

    // Word accesses select a byte-lane pair by offset[1]; byte accesses select one lane.
    assign byte_en = bus.length ? (bus.offset[1] ? 4'b1100 : 4'b0011)
                                : (4'b0001 << bus.offset[1:0]);

    // State register and strobe-width counter; the counter restarts on every state change.
    always_ff @(posedge clk40m) begin
        if (reset) begin
            cur_state  <= ST_WAIT;
            strobe_cnt <= 4'd0;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state) begin
                strobe_cnt <= 4'd0;
            end else if (strobe_cnt != 4'hF) begin
                strobe_cnt <= strobe_cnt + 4'd1;
            end
        end
    end

    // Next-state selection; a pending burst word outranks a new addressed command.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_WAIT:   if (bus.NewCommand) next_state = ST_ADDR0;
            ST_ADDR0:  next_state = ST_ADDR1;
            ST_ADDR1:  if (strobe_done) next_state = ST_ADDR2;
            ST_ADDR2:  next_state = wr_q ? ST_WRITE0 : ST_READ0;
            ST_READ0:  next_state = ST_READ1;
            ST_READ1:  if (strobe_done) next_state = ST_READ2;
            ST_WRITE0: next_state = ST_WRITE1;
            ST_WRITE1: if (strobe_done) next_state = ST_WRITE2;
            ST_READ2, ST_WRITE2: begin
                if (bus.Dummy_Write) begin
                    next_state = ST_WRITE0;
                end else if (bus.NewCommand) begin
                    next_state = ST_ADDR0;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            default:   next_state = ST_WAIT;
        endcase
    end

    // Pin levels per state; rdn and wrn are never decoded low in the same state.
    always_comb begin
        csn       = 1'b0;
        rdn       = 1'b1;
        wrn       = 1'b1;
        cmd_phase = 1'b0;
        drive_en  = 1'b0;
        case (cur_state)
            ST_ADDR0, ST_ADDR2: begin
                cmd_phase = 1'b1;
                drive_en  = 1'b1;
            end
            ST_ADDR1: begin
                cmd_phase = 1'b1;
                drive_en  = 1'b1;
                wrn       = 1'b0;
            end
            ST_READ0, ST_READ1: rdn = 1'b0;
            ST_READ2:           rdn = 1'b1;
            ST_WRITE0, ST_WRITE2: drive_en = 1'b1;
            ST_WRITE1: begin
                drive_en = 1'b1;
                wrn      = 1'b0;
            end
            default:   csn = 1'b1;
        endcase
    end

    // Datapath captures: the command word and direction in Addr0, the write word
    // in Write0, and the bus word at the Read2 exit edge. Only the direction has to
    // persist, so a burst never disturbs the addressed register.
    always_ff @(posedge clk40m) begin
        if (reset) begin
            wr_q     <= 1'b0;
            data_reg <= 16'h0000;
            read_reg <= 16'h0000;
        end else begin
            case (cur_state)
                ST_ADDR0: begin
                    wr_q     <= bus.WR;
                    data_reg <= {byte_en, 4'b0000, bus.offset};
                end
                ST_WRITE0: data_reg <= bus.writeData;
                ST_READ2:  read_reg <= bus.eth_data_in;
                default: ;
            endcase
        end
    end

    assign bus.state        = cur_state;
    assign bus.readData     = read_reg;
    assign bus.eth_csn      = csn;
    assign bus.eth_rdn      = rdn;
    assign bus.eth_wrn      = wrn;
    assign bus.eth_cmd      = cmd_phase;
    assign bus.eth_data_out = data_reg;
    assign bus.eth_data_oe  = drive_en;

endmodule

// File: tb/tb_ksz8851_bus_cycle.sv
// Self-checking bench for ksz8851_bus_cycle. A transaction-level model turns
// each request into the expected per-clock state sequence, bus word and
// captured read data; inputs the engine must ignore are randomised.
`timescale 1ns/1ps
module tb_ksz8851_bus_cycle;

    localparam logic [3:0] S_ADDR0  = 4'd0;
    localparam logic [3:0] S_ADDR1  = 4'd1;
    localparam logic [3:0] S_ADDR2  = 4'd2;
    localparam logic [3:0] S_READ0  = 4'd3;
    localparam logic [3:0] S_READ1  = 4'd4;
    localparam logic [3:0] S_READ2  = 4'd5;
    localparam logic [3:0] S_WRITE0 = 4'd6;
    localparam logic [3:0] S_WRITE1 = 4'd7;
    localparam logic [3:0] S_WRITE2 = 4'd8;
    localparam logic [3:0] S_WAIT   = 4'd9;

    typedef struct packed {
        logic [7:0]  off;
        logic        len;
        logic        wr;
        logic [15:0] wd;
        logic        nc;
        logic        dw;
        logic [15:0] bus_in;
    } stim_t;

    typedef struct packed {
        logic [3:0]  st;
        logic        chk;
        logic [15:0] dat;
        logic [15:0] rd;
    } exp_t;

    logic        clk40m = 1'b0;
    logic        reset;
    logic [7:0]  drv_offset;
    logic        drv_length;
    logic        drv_wr;
    logic [15:0] drv_write_data;
    logic        drv_new_command;
    logic        drv_dummy_write;
    logic [15:0] drv_bus_in;

    int          assert_count = 0;
    int          fail_count   = 0;
    stim_t       stim_q[$];
    exp_t        exp_q[$];
    int          model_sc;
    logic [15:0] model_rd;
    int          exp_wr_pulses;
    int          exp_rd_pulses;

    always #12.5 clk40m = ~clk40m;

    ksz8851_bus_cycle_if fast_if();
    ksz8851_bus_cycle_if slow_if();

    assign fast_if.offset      = drv_offset;
    assign fast_if.length      = drv_length;
    assign fast_if.WR          = drv_wr;
    assign fast_if.writeData   = drv_write_data;
    assign fast_if.NewCommand  = drv_new_command;
    assign fast_if.Dummy_Write = drv_dummy_write;
    assign fast_if.eth_data_in = drv_bus_in;
    assign slow_if.offset      = drv_offset;
    assign slow_if.length      = drv_length;
    assign slow_if.WR          = drv_wr;
    assign slow_if.writeData   = drv_write_data;
    assign slow_if.NewCommand  = drv_new_command;
    assign slow_if.Dummy_Write = drv_dummy_write;
    assign slow_if.eth_data_in = drv_bus_in;

    ksz8851_bus_cycle #(.STROBE_CYCLES(1)) dut_fast (
        .clk40m (clk40m),
        .reset  (reset),
        .bus    (fast_if.slave)
    );

    ksz8851_bus_cycle #(.STROBE_CYCLES(3)) dut_slow (
        .clk40m (clk40m),
        .reset  (reset),
        .bus    (slow_if.slave)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        assert_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Pin levels each cycle state calls for: {csn, rdn, wrn, cmd, oe}.
    function automatic logic [4:0] expected_pins(input logic [3:0] st);
        case (st)
            S_ADDR0, S_ADDR2:   return 5'b01111;
            S_ADDR1:            return 5'b01011;
            S_READ0, S_READ1:   return 5'b00100;
            S_READ2:            return 5'b01100;
            S_WRITE0, S_WRITE2: return 5'b01101;
            S_WRITE1:           return 5'b01001;
            default:            return 5'b11100;
        endcase
    endfunction

    task automatic push_cycle(input logic [3:0] st, input logic chk, input logic [15:0] dat);
        stim_t s;
        exp_t  e;
        s.off    = 8'($urandom);
        s.len    = 1'($urandom);
        s.wr     = 1'($urandom);
        s.wd     = 16'($urandom);
        s.bus_in = 16'($urandom);
        s.nc     = 1'($urandom);
        s.dw     = 1'($urandom);
        if (st == S_WAIT || st == S_READ2 || st == S_WRITE2) s.nc = 1'b0;
        if (st == S_READ2 || st == S_WRITE2) s.dw = 1'b0;
        e.st  = st;
        e.chk = chk;
        e.dat = dat;
        e.rd  = model_rd;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_data_phase(input logic [15:0] wd);
        push_cycle(S_WRITE0, 1'b0, 16'h0000);
        stim_q[stim_q.size()-1].wd = wd;
        for (int i = 0; i < model_sc; i++) push_cycle(S_WRITE1, 1'b1, wd);
        push_cycle(S_WRITE2, 1'b1, wd);
        exp_wr_pulses++;
    endtask

    task automatic add_command(input logic [7:0] off, input logic len, input logic wr,
                               input logic [15:0] wd, input logic [15:0] bus_word);
        int          first_byte;
        int          n_bytes;
        int          last;
        logic [3:0]  be;
        logic [15:0] cmd_word;
        last = stim_q.size() - 1;
        stim_q[last].nc = 1'b1;
        stim_q[last].dw = 1'b0;
        first_byte = len ? (off[1] ? 2 : 0) : int'(off[1:0]);
        n_bytes    = len ? 2 : 1;
        for (int b = 0; b < 4; b++) be[b] = (b >= first_byte) && (b < first_byte + n_bytes);
        cmd_word = {be, 4'h0, off};
        push_cycle(S_ADDR0, 1'b0, 16'h0000);
        last = stim_q.size() - 1;
        stim_q[last].off = off;
        stim_q[last].len = len;
        stim_q[last].wr  = wr;
        for (int i = 0; i < model_sc; i++) push_cycle(S_ADDR1, 1'b1, cmd_word);
        push_cycle(S_ADDR2, 1'b1, cmd_word);
        exp_wr_pulses++;
        if (wr) begin
            push_data_phase(wd);
        end else begin
            push_cycle(S_READ0, 1'b0, 16'h0000);
            for (int i = 0; i < model_sc; i++) push_cycle(S_READ1, 1'b0, 16'h0000);
            push_cycle(S_READ2, 1'b0, 16'h0000);
            stim_q[stim_q.size()-1].bus_in = bus_word;
            model_rd = bus_word;
            exp_rd_pulses++;
        end
    endtask

    task automatic add_dummy(input logic [15:0] wd);
        int last;
        last = stim_q.size() - 1;
        stim_q[last].dw = 1'b1;
        stim_q[last].nc = 1'($urandom);
        push_data_phase(wd);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push_cycle(S_WAIT, 1'b0, 16'h0000);
    endtask

    task automatic add_random_traffic(input int count);
        logic [7:0]  o;
        logic        l;
        logic        w;
        logic [15:0] wd;
        logic [15:0] bw;
        int          n_dummy;
        for (int t = 0; t < count; t++) begin
            o  = 8'($urandom);
            l  = 1'($urandom);
            w  = 1'($urandom);
            wd = 16'($urandom);
            bw = 16'($urandom);
            add_command(o, l, w, wd, bw);
            n_dummy = $urandom_range(0, 2);
            for (int d = 0; d < n_dummy; d++) add_dummy(16'($urandom));
            if ($urandom_range(0, 1) == 1) add_idle($urandom_range(1, 2));
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        drv_offset      = s.off;
        drv_length      = s.len;
        drv_wr          = s.wr;
        drv_write_data  = s.wd;
        drv_new_command = s.nc;
        drv_dummy_write = s.dw;
        drv_bus_in      = s.bus_in;
    endtask

    task automatic checkOutput(input bit use_slow, input exp_t e, input int cyc);
        logic [3:0]  st;
        logic        csn, rdn, wrn, cmd, oe;
        logic [15:0] rd, dat;
        logic [4:0]  pins;
        if (use_slow) begin
            st = slow_if.state;   csn = slow_if.eth_csn; rdn = slow_if.eth_rdn;
            wrn = slow_if.eth_wrn; cmd = slow_if.eth_cmd; oe = slow_if.eth_data_oe;
            rd = slow_if.readData; dat = slow_if.eth_data_out;
        end else begin
            st = fast_if.state;   csn = fast_if.eth_csn; rdn = fast_if.eth_rdn;
            wrn = fast_if.eth_wrn; cmd = fast_if.eth_cmd; oe = fast_if.eth_data_oe;
            rd = fast_if.readData; dat = fast_if.eth_data_out;
        end
        pins = expected_pins(e.st);
        check_val($sformatf("cycle %0d state", cyc), 16'(st), 16'(e.st));
        check_val($sformatf("cycle %0d csn", cyc), 16'(csn), 16'(pins[4]));
        check_val($sformatf("cycle %0d rdn", cyc), 16'(rdn), 16'(pins[3]));
        check_val($sformatf("cycle %0d wrn", cyc), 16'(wrn), 16'(pins[2]));
        check_val($sformatf("cycle %0d cmd", cyc), 16'(cmd), 16'(pins[1]));
        check_val($sformatf("cycle %0d oe", cyc), 16'(oe), 16'(pins[0]));
        check_val($sformatf("cycle %0d readData", cyc), rd, e.rd);
        if (e.chk) check_val($sformatf("cycle %0d data_out", cyc), dat, e.dat);
    endtask

    task automatic run_queue(input bit use_slow, input string name);
        int    cyc      = 0;
        int    wr_falls = 0;
        int    rd_falls = 0;
        logic  prev_wrn = 1'b1;
        logic  prev_rdn = 1'b1;
        logic  cur_wrn;
        logic  cur_rdn;
        stim_t s;
        exp_t  e;
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            checkOutput(use_slow, e, cyc);
            cur_wrn = use_slow ? slow_if.eth_wrn : fast_if.eth_wrn;
            cur_rdn = use_slow ? slow_if.eth_rdn : fast_if.eth_rdn;
            if (prev_wrn && !cur_wrn) wr_falls++;
            if (prev_rdn && !cur_rdn) rd_falls++;
            prev_wrn = cur_wrn;
            prev_rdn = cur_rdn;
            applyStimulus(s);
            @(posedge clk40m); #1;
            cyc++;
        end
        check_val({name, " wrn pulses"}, 16'(wr_falls), 16'(exp_wr_pulses));
        check_val({name, " rdn pulses"}, 16'(rd_falls), 16'(exp_rd_pulses));
    endtask

    task automatic wait_fast_state(input logic [3:0] target, input string tag);
        int n = 0;
        while (fast_if.state !== target && n < 30) begin
            @(posedge clk40m); #1;
            n++;
        end
        check_val(tag, 16'(fast_if.state), 16'(target));
    endtask

    initial begin
        exp_t        reset_exp;
        logic [15:0] chain_word;

        reset           = 1'b1;
        drv_offset      = 8'h00;
        drv_length      = 1'b0;
        drv_wr          = 1'b0;
        drv_write_data  = 16'h0000;
        drv_new_command = 1'b0;
        drv_dummy_write = 1'b0;
        drv_bus_in      = 16'h0000;
        reset_exp.st  = S_WAIT;
        reset_exp.chk = 1'b1;
        reset_exp.dat = 16'h0000;
        reset_exp.rd  = 16'h0000;

        repeat (3) @(posedge clk40m);
        #1;
        checkOutput(1'b0, reset_exp, -1);
        checkOutput(1'b1, reset_exp, -1);
        reset = 1'b0;

        $display("[TB] STROBE_CYCLES=1: directed and randomised requests");
        model_sc      = 1;
        model_rd      = 16'h0000;
        exp_wr_pulses = 0;
        exp_rd_pulses = 0;
        add_idle(2);
        add_command(8'h78, 1'b1, 1'b0, 16'h0000, 16'h1F40);
        add_idle(2);
        add_command(8'h90, 1'b1, 1'b1, 16'h0000, 16'h0000);
        add_idle(1);
        chain_word = 16'($urandom) & 16'hFFF7;
        add_command(8'h82, 1'b1, 1'b0, 16'h0000, chain_word);
        add_command(8'h82, 1'b1, 1'b1, chain_word | 16'h0008, 16'h0000);
        add_idle(1);
        add_command(8'hC8, 1'b1, 1'b1, 16'h8000, 16'h0000);
        add_dummy(16'h0040);
        for (int i = 0; i < 32; i++) add_dummy(16'h2345);
        add_command(8'($urandom), 1'b1, 1'b0, 16'h0000, 16'($urandom));
        add_idle(2);
        add_random_traffic(12);
        add_idle(2);
        run_queue(1'b0, "fast");

        reset = 1'b1;
        @(posedge clk40m); #1;
        reset = 1'b0;
        $display("[TB] STROBE_CYCLES=3: byte read and randomised requests");
        model_sc      = 3;
        model_rd      = 16'h0000;
        exp_wr_pulses = 0;
        exp_rd_pulses = 0;
        add_idle(2);
        add_command(8'h93, 1'b0, 1'b0, 16'h0000, 16'($urandom));
        add_idle(1);
        add_random_traffic(5);
        add_idle(2);
        run_queue(1'b1, "slow");

        $display("[TB] reset asserted during the write strobe");
        reset = 1'b1;
        @(posedge clk40m); #1;
        reset           = 1'b0;
        drv_offset      = 8'h90;
        drv_length      = 1'b1;
        drv_wr          = 1'b0;
        drv_write_data  = 16'h5AA5;
        drv_bus_in      = 16'hBEEF;
        drv_dummy_write = 1'b0;
        drv_new_command = 1'b1;
        wait_fast_state(S_READ2, "reach Read2");
        drv_wr = 1'b1;
        @(posedge clk40m); #1;
        wait_fast_state(S_WRITE1, "reach Write1");
        check_val("readData before reset", fast_if.readData, 16'hBEEF);
        check_val("wrn low before reset", 16'(fast_if.eth_wrn), 16'h0000);
        reset           = 1'b1;
        drv_new_command = 1'b0;
        @(posedge clk40m); #1;
        checkOutput(1'b0, reset_exp, -2);
        reset = 1'b0;
        repeat (2) @(posedge clk40m);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
